iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//  Multi-cycle radix-2 restoring divider; the responder side of the EX-stage div_en/done handshake.
//  EX holds div_en high and stalls until done; the divider returns {remainder, quotient} for the HI/LO write.
//  Serves DIV (signed) and DIVU (unsigned). One result per request; cancellable by pipeline flush.
// PARAMETERS
//  DATA_WIDTH  32  operand width; result is 2*DATA_WIDTH; iteration count = DATA_WIDTH
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous active-low reset
//  div_en      in   1       request; held high by EX while stalled on a divide
//  sign_en     in   1       1=signed (DIV), 0=unsigned (DIVU); sampled with div_en in IDLE
//  operand_1   in   32      dividend; sampled with div_en in IDLE
//  operand_2   in   32      divisor; sampled with div_en in IDLE
//  result_ack  in   1       EX advances past the divide; consumes the result
//  cancel      in   1       flush (exception/eret); aborts any operation
//  done        out  1       result valid; held until result_ack or cancel
//  busy        out  1       high in CALC
//  result      out  64      {remainder[63:32] -> HI, quotient[31:0] -> LO}
// BEHAVIOUR
//  - One clock, asynchronous active-low reset: clk, rst_n. Reset: state=IDLE, done=0, busy=0, result=0, count=0.
//  - States: IDLE -> CALC -> DONE -> IDLE. cancel has priority over all transitions: next state IDLE, done=0, result kept.
//  - IDLE: at edge N with div_en=1, latch |op1|, |op2| (abs only if sign_en), q_sign=op1[31]^op2[31], r_sign=op1[31].
//    Same edge: clear partial remainder, set count=0, go to CALC. div_en=0: stay.
//  - CALC: one restoring step per edge: rem={rem,quo_msb}; if rem>=divisor subtract and shift in 1, else shift in 0.
//    count is incremented each step. After the DATA_WIDTH-th step (edge N+32), apply sign fix and register the result.
//    Then go to DONE at edge N+33; done=1 from edge N+33 (33 cycles after the sampling edge). busy=1 only in CALC.
//  - Sign fix (signed only): quotient negated if q_sign; remainder negated if r_sign (remainder takes dividend sign).
//    All arithmetic is modulo 2^32: 0x80000000 / 0xFFFFFFFF (signed) -> q=0x80000000, r=0. No overflow flag.
//  - Divisor zero: detected in IDLE; skips CALC and goes to DONE at edge N+1 with q=0xFFFFFFFF, r=operand_1 unmodified.
//  - DONE: done=1, result stable. result_ack=1 -> IDLE next edge, done=0. div_en is ignored in DONE.
//    A new request is therefore taken only from IDLE, at the earliest one edge after the ack.
//  - Back-to-back divides: div_en may stay high across ack; a new operation starts on the first IDLE edge.
//  - result_ack in IDLE/CALC: ignored. div_en dropping in CALC without cancel: operation completes, waits in DONE.
//  - Reset mid-operation: immediate return to reset values; no partial result visible.
// CONFIGURATION
//  DIV_EARLY_OUT_EN defined:
//    In IDLE, if |dividend| < |divisor| (divisor nonzero), skip CALC and go to DONE at edge N+1.
//    Result: q=0, r=operand_1 (already correctly signed).
//  DIV_EARLY_OUT_EN undefined: every nonzero-divisor operation takes the full 33-cycle path; results identical.
// TESTING
//  1 Unsigned: sign_en=0, 100/7 -> done exactly 33 cycles after sampling edge, result={32'd2, 32'd14}, busy=1 for 32 cycles.
//  2 Signed: -7/2 (0xFFFFFFF9/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; also 7/-2 -> q=0xFFFFFFFD, r=1;
//    also 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
//  3 Divide by zero: 0x1234/0 -> done one cycle after sampling edge, q=0xFFFFFFFF, r=0x1234.
//  4 Cancel: assert cancel at CALC step 10 -> IDLE next edge, done never rises.
//    Next request 50/5 -> {0, 10} on the full-length path.
//  5 Hold/ack: keep result_ack=0 for 5 cycles in DONE -> done and result stable.
//    ack with div_en still high (new ops 9/4) -> done low for >=1 cycle, then second result {1, 2}.
//  6 Reset: drop rst_n mid-CALC -> all outputs 0 asynchronously.
//    With DIV_EARLY_OUT_EN: 3/10 -> done one cycle after sampling edge, {3, 0}; without it: 33 cycles, same result.

Source files
------------

// File: rtl/iter_divider.sv
// Radix-2 restoring divider serving DIV/DIVU for the EX stage.
// Optional early-out for |dividend| < |divisor|: define DIV_EARLY_OUT_EN.
module iter_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      div_en,
    input  logic                      sign_en,
    input  logic [DATA_WIDTH-1:0]     operand_1,
    input  logic [DATA_WIDTH-1:0]     operand_2,
    input  logic                      result_ack,
    input  logic                      cancel,
    output logic                      done,
    output logic                      busy,
    output logic [2*DATA_WIDTH-1:0]   result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    // FIN is the single cycle between the final step and done rising
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    dvs_q;
    logic [W-1:0]    rem_q;
    logic [CW-1:0]   count_q;
    logic            q_sign_q;
    logic            r_sign_q;
    logic            done_q;
    logic            busy_q;
    logic [2*W-1:0]  result_q;

    logic [W-1:0]    abs1;
    logic [W-1:0]    abs2;
    logic            div_zero;
    logic            early_out;
    logic [W:0]      rem_sh;
    logic [W:0]      rem_diff;
    logic            rem_ge;
    logic [W-1:0]    rem_d;
    logic [W-1:0]    quo_d;
    logic [W-1:0]    q_fix;
    logic [W-1:0]    r_fix;

    // Operand magnitudes, zero/early-out detection and one restoring step
    always_comb begin
        abs1 = operand_1;
        abs2 = operand_2;
        if (sign_en && operand_1[W-1]) begin
            abs1 = W'(0) - operand_1;
        end
        if (sign_en && operand_2[W-1]) begin
            abs2 = W'(0) - operand_2;
        end
        div_zero = (operand_2 == W'(0));
`ifdef DIV_EARLY_OUT_EN
        early_out = !div_zero && (abs1 < abs2);
`else
        early_out = 1'b0;
`endif
        rem_sh   = {rem_q, quo_q[W-1]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        rem_ge   = (rem_sh >= {1'b0, dvs_q});
        rem_d    = rem_ge ? rem_diff[W-1:0] : rem_sh[W-1:0];
        quo_d    = {quo_q[W-2:0], rem_ge};
        q_fix    = q_sign_q ? (W'(0) - quo_d) : quo_d;
        r_fix    = r_sign_q ? (W'(0) - rem_d) : rem_d;
    end

    // Control FSM with registered done/busy/result; cancel overrides all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            quo_q    <= '0;
            dvs_q    <= '0;
            rem_q    <= '0;
            count_q  <= '0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            result_q <= '0;
        end else if (cancel) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (div_en) begin
                        if (div_zero) begin
                            result_q <= {operand_1, {W{1'b1}}};
                            state_q  <= S_FIN;
                        end else if (early_out) begin
                            result_q <= {operand_1, {W{1'b0}}};
                            state_q  <= S_FIN;
                        end else begin
                            quo_q    <= abs1;
                            dvs_q    <= abs2;
                            rem_q    <= '0;
                            count_q  <= '0;
                            q_sign_q <= sign_en &
                                        (operand_1[W-1] ^ operand_2[W-1]);
                            r_sign_q <= sign_en & operand_1[W-1];
                            busy_q   <= 1'b1;
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    quo_q   <= quo_d;
                    rem_q   <= rem_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(W - 1)) begin
                        result_q <= {r_fix, q_fix};
                        busy_q   <= 1'b0;
                        state_q  <= S_FIN;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (result_ack) begin
                        done_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign done   = done_q;
    assign busy   = busy_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed testbench for iter_divider.
// Latency is counted in edges after the sampling edge.
module tb_iter_divider;

    logic        clk;
    logic        rst_n;
    logic        div_en;
    logic        sign_en;
    logic [31:0] operand_1;
    logic [31:0] operand_2;
    logic        result_ack;
    logic        cancel;
    logic        done;
    logic        busy;
    logic [63:0] result;

    int pass_cnt;
    int total_cnt;

    iter_divider #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_en     (div_en),
        .sign_en    (sign_en),
        .operand_1  (operand_1),
        .operand_2  (operand_2),
        .result_ack (result_ack),
        .cancel     (cancel),
        .done       (done),
        .busy       (busy),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request, pass the sampling edge, wait (bounded) for done
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic sg, input logic keep,
                          output int lat, output int bcnt);
        operand_1 = a;
        operand_2 = b;
        sign_en   = sg;
        div_en    = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) div_en = 1'b0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        while (!done && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total_cnt++;
        if ({done, busy, result} !== 66'd0) begin
            $display("FAIL reset_outputs: got done=%b busy=%b result=%h want 0",
                     done, busy, result);
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned();
        int lat;
        int bc;
        run_op(32'd100, 32'd7, 1'b0, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 33) $display("FAIL unsigned_latency: got %0d want 33", lat);
        else pass_cnt++;
        total_cnt++;
        if (bc !== 32) $display("FAIL unsigned_busy: got %0d want 32", bc);
        else pass_cnt++;
        total_cnt++;
        if (result !== {32'd2, 32'd14})
            $display("FAIL unsigned_result: got %h want %h",
                     result, {32'd2, 32'd14});
        else pass_cnt++;
        do_ack();
        total_cnt++;
        if (done !== 1'b0) $display("FAIL unsigned_ack: done=%b want 0", done);
        else pass_cnt++;
    endtask

    task automatic test_signed();
        logic [31:0] a_t [3];
        logic [31:0] b_t [3];
        logic [63:0] e_t [3];
        int lat;
        int bc;
        a_t[0] = 32'hFFFF_FFF9; b_t[0] = 32'd2;
        e_t[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        a_t[1] = 32'd7;         b_t[1] = 32'hFFFF_FFFE;
        e_t[1] = {32'd1, 32'hFFFF_FFFD};
        a_t[2] = 32'h8000_0000; b_t[2] = 32'hFFFF_FFFF;
        e_t[2] = {32'd0, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            run_op(a_t[i], b_t[i], 1'b1, 1'b0, lat, bc);
            total_cnt++;
            if (lat !== 33 || result !== e_t[i])
                $display("FAIL signed_%0d: got lat=%0d result=%h want lat=33 result=%h",
                         i, lat, result, e_t[i]);
            else pass_cnt++;
            do_ack();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        int bc;
        run_op(32'h1234, 32'd0, 1'b1, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 1) $display("FAIL divzero_latency: got %0d want 1", lat);
        else pass_cnt++;
        total_cnt++;
        if (result !== {32'h1234, 32'hFFFF_FFFF})
            $display("FAIL divzero_result: got %h want %h",
                     result, {32'h1234, 32'hFFFF_FFFF});
        else pass_cnt++;
        do_ack();
    endtask

    task automatic test_cancel();
        int lat;
        int bc;
        logic saw;
        operand_1 = 32'd1000;
        operand_2 = 32'd3;
        sign_en   = 1'b0;
        div_en    = 1'b1;
        @(posedge clk);
        #1;
        div_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        total_cnt++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL cancel_idle: got busy=%b done=%b want 0 0", busy, done);
        else pass_cnt++;
        saw = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) saw = 1'b1;
        end
        total_cnt++;
        if (saw !== 1'b0) $display("FAIL cancel_no_done: got done seen=%b want 0", saw);
        else pass_cnt++;
        run_op(32'd50, 32'd5, 1'b0, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 33 || result !== {32'd0, 32'd10})
            $display("FAIL cancel_next: got lat=%0d result=%h want lat=33 result=%h",
                     lat, result, {32'd0, 32'd10});
        else pass_cnt++;
        do_ack();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        logic stable;
        run_op(32'd20, 32'd3, 1'b0, 1'b0, lat, bc);
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (done !== 1'b1 || result !== {32'd2, 32'd6}) stable = 1'b0;
        end
        total_cnt++;
        if (stable !== 1'b1)
            $display("FAIL hold_stable: got done=%b result=%h want 1 %h",
                     done, result, {32'd2, 32'd6});
        else pass_cnt++;
        operand_1  = 32'd9;
        operand_2  = 32'd4;
        sign_en    = 1'b0;
        div_en     = 1'b1;
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        result_ack = 1'b0;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL b2b_done_low: got %b want 0", done);
        else pass_cnt++;
        run_op(32'd9, 32'd4, 1'b0, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== 33 || result !== {32'd1, 32'd2})
            $display("FAIL b2b_second: got lat=%0d result=%h want lat=33 result=%h",
                     lat, result, {32'd1, 32'd2});
        else pass_cnt++;
        do_ack();
    endtask

    task automatic test_async_reset();
        int lat;
        int bc;
        int exp_lat;
        operand_1 = 32'd100;
        operand_2 = 32'd7;
        sign_en   = 1'b0;
        div_en    = 1'b1;
        @(posedge clk);
        #1;
        div_en = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b want 1", busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({done, busy, result} !== 66'd0)
            $display("FAIL rst_async: got done=%b busy=%b result=%h want 0",
                     done, busy, result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
`ifdef DIV_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = 33;
`endif
        run_op(32'd3, 32'd10, 1'b1, 1'b0, lat, bc);
        total_cnt++;
        if (lat !== exp_lat || result !== {32'd3, 32'd0})
            $display("FAIL small_dividend: got lat=%0d result=%h want lat=%0d result=%h",
                     lat, result, exp_lat, {32'd3, 32'd0});
        else pass_cnt++;
        do_ack();
    endtask

    initial begin
        pass_cnt   = 0;
        total_cnt  = 0;
        div_en     = 1'b0;
        sign_en    = 1'b0;
        operand_1  = '0;
        operand_2  = '0;
        result_ack = 1'b0;
        cancel     = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_cancel();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
